// File: rtl/drm_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drm_fifo_pkg                                                             |
// | Shared constants and helpers for the drm_sync_fifo block: read-mode      |
// | selectors, RAM read latency and occupancy counter width.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package drm_fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Cycles from a RAM read request to data on the RAM output.
   function automatic int rd_lat(input int output_reg);
      return 1 + ((output_reg != 0) ? 1 : 0);
   endfunction

   // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
   function automatic int count_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/drm_sdpram_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drm_sdpram_core                                                          |
// | Inferred simple-dual-port RAM: one write port, one registered read port, |
// | optional extra output register.                                          |
// | Ports: clk, rst_n (async, active-low; read registers only),              |
// |        wr_en/wr_addr/wr_data (write), rd_en/rd_addr (read request),      |
// |        rd_data (read word, 1 + OUTPUT_REG cycles after rd_en).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module drm_sdpram_core #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int OUTPUT_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   // Array is deliberately left without reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register only loads on a request, so the word holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else if (rd_en) rd_q <= mem[rd_addr];
   end

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic                  rd_en_q;
         logic [DATA_WIDTH-1:0] out_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_en_q <= 1'b0;
               out_q   <= '0;
            end else begin
               rd_en_q <= rd_en;
               if (rd_en_q) out_q <= rd_q;
            end
         end
         assign rd_data = out_q;
      end else begin : g_noreg
         assign rd_data = rd_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/drm_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drm_sync_fifo                                                            |
// | Single-clock FIFO on an inferred SDP RAM, standard or FWFT read mode,    |
// | with occupancy count, almost-flags and overflow/underflow pulses.        |
// | Ports: clk, rst_n (async, active-low), wr_data/wr_en (push),             |
// |        rd_en (pop / FWFT acknowledge), rd_data/rd_valid (read side),     |
// |        full/empty/almost_full/almost_empty, count, overflow/underflow.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module drm_sync_fifo
   import drm_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int OUTPUT_REG = 0,
   parameter int FWFT       = FIFO_STD,
   parameter int AF_TH      = (2**ADDR_WIDTH) - 4,
   parameter int AE_TH      = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [DATA_WIDTH-1:0]               wr_data,
   input  logic                                wr_en,
   input  logic                                rd_en,
   output logic [DATA_WIDTH-1:0]               rd_data,
   output logic                                rd_valid,
   output logic                                full,
   output logic                                empty,
   output logic                                almost_full,
   output logic                                almost_empty,
   output logic [count_width(ADDR_WIDTH)-1:0]  count,
   output logic                                overflow,
   output logic                                underflow
);

   localparam int DEPTH  = 2**ADDR_WIDTH;
   localparam int RD_LAT = rd_lat(OUTPUT_REG);
   localparam int CNT_W  = count_width(ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      count_nxt;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  ram_rd;
   logic                  empty_nxt;
   logic [RD_LAT-1:0]     rd_pipe;    // one bit per RAM read in flight
   logic                  land;       // RAM output carries a fresh word
   logic [DATA_WIDTH-1:0] ram_dout;

   assign push_ok = wr_en && !full;
   assign pop_ok  = rd_en && !empty;
   assign land    = rd_pipe[RD_LAT-1];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)      count_nxt = count + CNT_W'(1);
      else if (!push_ok && pop_ok) count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_TH == 0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         rd_pipe      <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (ram_rd)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         count        <= count_nxt;
         full         <= (count_nxt == CNT_W'(DEPTH));
         empty        <= empty_nxt;
         almost_full  <= (int'(count_nxt) >= AF_TH);
         almost_empty <= (int'(count_nxt) <= AE_TH);
         overflow     <= wr_en && full;
         // A pop paired with a push into an empty FIFO is not an error.
         underflow    <= rd_en && empty && !wr_en;
         rd_pipe[0]   <= ram_rd;
         for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   drm_sdpram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .OUTPUT_REG (OUTPUT_REG)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr),
      .rd_data (ram_dout)
   );

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         // Prefetch buffer deep enough to cover the RAM latency plus the head.
         localparam int PF_DEPTH = RD_LAT + 1;
         localparam int PF_W     = $clog2(PF_DEPTH + 2);

         logic [PF_W-1:0]       pf_cnt;
         logic [PF_W-1:0]       pf_cnt_nxt;
         logic [PF_W-1:0]       in_flight;
         logic [PF_W-1:0]       wr_idx;
         logic [CNT_W-1:0]      ram_cnt;    // words in RAM not yet read out
         logic [DATA_WIDTH-1:0] pf_buf [PF_DEPTH];
         logic                  issue;

         always_comb begin
            in_flight = '0;
            for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + PF_W'(rd_pipe[i]);
         end

         // Reserve a slot for every in-flight read; a pop this cycle frees one,
         // which is what lets the stream run at one word per cycle.
         assign issue      = (ram_cnt != '0) &&
                             ((pf_cnt + in_flight) < (PF_W'(PF_DEPTH) + PF_W'(pop_ok)));
         assign pf_cnt_nxt = pf_cnt + PF_W'(land) - PF_W'(pop_ok);
         assign wr_idx     = pf_cnt - PF_W'(pop_ok);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ram_cnt <= '0;
               pf_cnt  <= '0;
               for (int i = 0; i < PF_DEPTH; i++) pf_buf[i] <= '0;
            end else begin
               ram_cnt <= ram_cnt + CNT_W'(push_ok) - CNT_W'(issue);
               pf_cnt  <= pf_cnt_nxt;
               if (pop_ok) begin
                  for (int i = 0; i < PF_DEPTH - 1; i++) pf_buf[i] <= pf_buf[i+1];
               end
               // Landing word goes behind whatever survives the pop.
               for (int i = 0; i < PF_DEPTH; i++) begin
                  if (land && (int'(wr_idx) == i)) pf_buf[i] <= ram_dout;
               end
            end
         end

         assign ram_rd    = issue;
         assign empty_nxt = (pf_cnt_nxt == '0);
         assign rd_data   = pf_buf[0];
         assign rd_valid  = !empty;
      end else begin : g_std
         assign ram_rd    = pop_ok;
         assign empty_nxt = (count_nxt == '0);
         assign rd_data   = ram_dout;
         assign rd_valid  = land;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_drm_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_drm_sync_fifo                                                         |
// | Drives one standard-mode and one FWFT (output-registered) FIFO with the  |
// | same stimulus and compares both against queue-based reference models.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_drm_sync_fifo;

   localparam int AW     = 4;
   localparam int DEPTH  = 16;
   localparam int AF     = 12;
   localparam int AE     = 2;
   localparam int F_LAT  = 2;   // RAM latency of the FWFT instance

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] wr_data = '0;

   logic [31:0] s_rd_data, f_rd_data;
   logic        s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
   logic        s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
   logic [AW:0] s_count, f_count;

   always #5 clk = ~clk;

   drm_sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .OUTPUT_REG(0), .FWFT(0),
                   .AF_TH(AF), .AE_TH(AE)) dut_s (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf));

   drm_sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .OUTPUT_REG(1), .FWFT(1),
                   .AF_TH(AF), .AE_TH(AE)) dut_f (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf));

   // ---------------- reference models ----------------
   typedef struct { logic [31:0] data; int avail; } fent_t;

   logic [31:0] s_q[$];
   logic [31:0] s_dat = '0;
   logic        s_vld = 1'b0, s_ovf_e = 1'b0, s_unf_e = 1'b0;
   fent_t       f_q[$];
   logic        f_ovf_e = 1'b0, f_unf_e = 1'b0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Head word is visible once its prefetch latency has elapsed.
   function automatic bit f_visible();
      return (f_q.size() != 0) && (f_q[0].avail <= cyc);
   endfunction

   task automatic model_step();
      bit    s_w, s_r, f_w, f_r, vis;
      fent_t e;
      s_w     = wr_en && (s_q.size() < DEPTH);
      s_r     = rd_en && (s_q.size() != 0);
      s_ovf_e = wr_en && (s_q.size() == DEPTH);
      s_unf_e = rd_en && (s_q.size() == 0) && !wr_en;
      s_vld   = 1'b0;
      if (s_r) begin
         s_dat = s_q.pop_front();
         s_vld = 1'b1;
      end
      if (s_w) s_q.push_back(wr_data);

      vis     = f_visible();
      f_w     = wr_en && (f_q.size() < DEPTH);
      f_r     = rd_en && vis;
      f_ovf_e = wr_en && (f_q.size() == DEPTH);
      f_unf_e = rd_en && !vis && !wr_en;
      cyc++;
      if (f_r) void'(f_q.pop_front());
      if (f_w) begin
         e.data  = wr_data;
         e.avail = cyc + 1 + F_LAT;
         f_q.push_back(e);
      end
   endtask

   task automatic model_reset();
      s_q.delete();
      f_q.delete();
      s_dat = '0; s_vld = 1'b0; s_ovf_e = 1'b0; s_unf_e = 1'b0;
      f_ovf_e = 1'b0; f_unf_e = 1'b0;
   endtask

   task automatic check_all();
      bit vis;
      chk("s_count", s_count, s_q.size());
      chk("s_full", s_full, s_q.size() == DEPTH);
      chk("s_empty", s_empty, s_q.size() == 0);
      chk("s_afull", s_af, s_q.size() >= AF);
      chk("s_aempty", s_ae, s_q.size() <= AE);
      chk("s_ovf", s_ovf, s_ovf_e);
      chk("s_unf", s_unf, s_unf_e);
      chk("s_rd_valid", s_rd_valid, s_vld);
      chk("s_rd_data", s_rd_data, s_dat);
      vis = f_visible();
      chk("f_count", f_count, f_q.size());
      chk("f_full", f_full, f_q.size() == DEPTH);
      chk("f_empty", f_empty, !vis);
      chk("f_afull", f_af, f_q.size() >= AF);
      chk("f_aempty", f_ae, f_q.size() <= AE);
      chk("f_ovf", f_ovf, f_ovf_e);
      chk("f_unf", f_unf, f_unf_e);
      chk("f_rd_valid", f_rd_valid, vis);
      if (vis) chk("f_rd_data", f_rd_data, f_q[0].data);
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge.
   task automatic cycle(input bit w, input bit r, input logic [31:0] d);
      wr_en = w; rd_en = r; wr_data = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
   endtask

   task automatic async_reset();
      wr_en = 1'b0; rd_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_s_count", s_count, 0);
      chk("rst_f_empty", f_empty, 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int lat;
      int gaps;

      // Reset state
      @(posedge clk); @(posedge clk); @(negedge clk);
      check_all();
      chk("rst_s_aempty", s_ae, 1);
      chk("rst_f_afull", f_af, 0);
      rst_n = 1'b1;

      // Fill 0..15, almost_full edge at 12, then overflow
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 1'b0, 32'(i));
         chk("fill_afull", s_af, (i + 1) >= AF);
      end
      chk("fill_full", s_full, 1);
      chk("fill_count", s_count, DEPTH);
      cycle(1'b1, 1'b0, 32'hDEAD);
      chk("ovf_pulse", s_ovf, 1);
      chk("ovf_count", s_count, DEPTH);
      idle(2);

      // Drain in order; almost_empty edge at 2
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, '0);
         chk("drain_data", s_rd_data, 32'(i));
         chk("drain_aempty", s_ae, (DEPTH - 1 - i) <= AE);
      end
      chk("drain_empty", s_empty, 1);
      idle(1);

      // Pop on empty alone -> underflow
      cycle(1'b0, 1'b1, '0);
      chk("unf_pulse", s_unf, 1);
      idle(1);

      // FWFT single-word latency
      cycle(1'b1, 1'b0, 32'hA5);
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b0, 1'b0, '0);
         if (lat == 0 && !f_empty) lat = k;
      end
      chk("fwft_latency", lat, 3);
      chk("fwft_head", f_rd_data, 32'hA5);
      cycle(1'b0, 1'b1, '0);
      chk("fwft_pop_empty", f_empty, 1);
      idle(2);

      // Both requests while full: pop only
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom);
      idle(4);
      cycle(1'b1, 1'b1, 32'h1234);
      chk("full_both_s", s_count, DEPTH - 1);
      chk("full_both_f", f_count, DEPTH - 1);
      idle(4);
      for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, '0);
      idle(2);

      // Both requests while empty: push only, no underflow
      cycle(1'b1, 1'b1, 32'h5678);
      chk("empty_both_s", s_count, 1);
      chk("empty_both_unf", s_unf, 0);
      chk("empty_both_f", f_count, 1);
      idle(4);
      cycle(1'b0, 1'b1, '0);
      idle(2);

      // Streaming at constant occupancy 8
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, $urandom);
      idle(4);
      gaps = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b1, 1'b1, $urandom);
         if (!s_rd_valid || !f_rd_valid || s_count != 8 || f_count != 8) gaps++;
      end
      chk("stream_gaps", gaps, 0);

      // Asynchronous reset mid-stream
      async_reset();
      cycle(1'b1, 1'b0, 32'hBEEF);
      chk("post_rst_push", s_count, 1);
      idle(4);
      cycle(1'b0, 1'b1, '0);
      idle(2);

      // Pointer wrap: three fill/drain rounds
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom);
         idle(4);
         for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
         idle(2);
      end

      // Random traffic with varying bias to visit full and empty
      for (int seg = 0; seg < 3; seg++) begin
         for (int i = 0; i < 700; i++) begin
            cycle($urandom_range(0, 99) < (70 - 20 * seg),
                  $urandom_range(0, 99) < (40 + 10 * seg),
                  $urandom);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
